// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : opcode map and controller state encoding shared by alu_seq
// Rev 1.0
// ============================================================================
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_LSH = 3'b011;
  localparam logic [2:0] OP_RSH = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_seq_mul.sv
`default_nettype none
// ============================================================================
// alu_seq_mul : iterative WIDTH-step shift-add multiplier, start/done handshake
// Rev 1.0
// ============================================================================
module alu_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_next;

  // Multiplier sits in the low half of acc and is consumed LSB-first while the
  // partial product shifts down from the high half.
  assign w_sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign w_acc_next = {w_sum, acc_q[WIDTH-1:1]};

  assign done_o = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign prod_o = w_acc_next;

  always_comb begin
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (start_i) begin
      mcand_d = a_i;
      acc_d   = {{WIDTH{1'b0}}, b_i};
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      acc_d = w_acc_next;
      cnt_d = cnt_q + 1'b1;
      if (done_o) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// alu_seq : registered, valid/ready handshaked ALU with iterative multiply
// Rev 1.0
// ============================================================================
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             carry,
  output logic [WIDTH-1:0] mul_hi,
  output logic             zero,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   mul_hi_q, mul_hi_d;
  logic               zero_q, zero_d;

  logic               w_accept;
  logic               w_mul_start;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;
  logic [SHW-1:0]     w_sh;
  logic [WIDTH:0]     w_add, w_sub, w_lsh, w_rsh;
  logic [WIDTH-1:0]   w_alu_y;
  logic               w_alu_c;

  assign in_ready    = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_mul_start = w_accept && (opcode == OP_MUL);

  // One-bit-wider shifts leave the last bit shifted out in the spare position,
  // which is 0 for a zero distance.
  assign w_sh  = B[SHW-1:0];
  assign w_add = {1'b0, A} + {1'b0, B};
  assign w_sub = {1'b0, A} - {1'b0, B};
  assign w_lsh = {1'b0, A} << w_sh;
  assign w_rsh = {A, 1'b0} >> w_sh;

  always_comb begin
    w_alu_y = '0;
    w_alu_c = 1'b0;
    case (opcode)
      OP_ADD: {w_alu_c, w_alu_y} = w_add;
      OP_SUB: {w_alu_c, w_alu_y} = w_sub;
      OP_LSH: {w_alu_c, w_alu_y} = w_lsh;
      OP_RSH: {w_alu_y, w_alu_c} = w_rsh;
      OP_AND: w_alu_y = A & B;
      OP_OR:  w_alu_y = A | B;
      OP_XOR: w_alu_y = A ^ B;
      default: w_alu_y = '0;
    endcase
  end

  alu_seq_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (w_mul_start),
    .a_i     (A),
    .b_i     (B),
    .done_o  (w_mul_done),
    .prod_o  (w_prod)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    carry_d     = carry_q;
    mul_hi_d    = mul_hi_q;
    zero_d      = zero_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          if (opcode == OP_MUL) begin
            state_d = ST_MUL;
          end else begin
            out_valid_d = 1'b1;
            y_d         = w_alu_y;
            carry_d     = w_alu_c;
            mul_hi_d    = '0;
            zero_d      = (w_alu_y == '0);
          end
        end
      end
      ST_MUL: begin
        // Output slot is guaranteed free here: MUL is only accepted when it is.
        if (w_mul_done) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
          y_d         = w_prod[WIDTH-1:0];
          carry_d     = 1'b0;
          mul_hi_d    = w_prod[2*WIDTH-1:WIDTH];
          zero_d      = (w_prod[WIDTH-1:0] == '0);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      carry_q     <= 1'b0;
      mul_hi_q    <= '0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      carry_q     <= carry_d;
      mul_hi_q    <= mul_hi_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Y         = y_q;
  assign carry     = carry_q;
  assign mul_hi    = mul_hi_q;
  assign zero      = zero_q;
  assign busy      = (state_q == ST_MUL);

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// tb_alu_seq : directed vectors, expected results queued and checked by monitor
// Rev 1.0
// ============================================================================
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A, B;
  logic [2:0] opcode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] Y;
  logic       carry;
  logic [7:0] mul_hi;
  logic       zero;
  logic       busy;

  typedef struct {
    logic [7:0] y;
    logic       c;
    logic [7:0] hi;
    logic       z;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .carry     (carry),
    .mul_hi    (mul_hi),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] ey, input logic ec, input logic [7:0] ehi);
    exp_t e;
    e.y  = ey;
    e.c  = ec;
    e.hi = ehi;
    e.z  = (ey == 8'h00);
    sb.push_back(e);
  endtask

  // Presents an op and returns just after its accept edge; in_valid is left high.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] ey, input logic ec, input logic [7:0] ehi,
                      output int waited);
    opcode   = op;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    push(ey, ec, ehi);
    waited = 0;
    while (!in_ready && waited < 40) begin
      tick();
      waited++;
    end
    if (!in_ready) chk("accept_timeout", 16'd0, 16'd1);
    tick();
  endtask

  // Monitor: a transfer happens at the next edge when both are high mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", {8'h00, Y}, 16'hFFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("Y",      {8'h00, Y},      {8'h00, e.y});
          chk("carry",  {15'h0, carry},  {15'h0, e.c});
          chk("mul_hi", {8'h00, mul_hi}, {8'h00, e.hi});
          chk("zero",   {15'h0, zero},   {15'h0, e.z});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = 8'h00;
    B         = 8'h00;
    opcode    = 3'b000;
    tick();
    tick();
    chk("rst_out_valid", {15'h0, out_valid}, 16'h0);
    chk("rst_Y",         {8'h00, Y},         16'h0);
    chk("rst_carry",     {15'h0, carry},     16'h0);
    chk("rst_mul_hi",    {8'h00, mul_hi},    16'h0);
    chk("rst_zero",      {15'h0, zero},      16'h0);
    chk("rst_busy",      {15'h0, busy},      16'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", {15'h0, in_ready}, 16'h1);

    // ADD with carry-out
    send(3'b000, 8'hF0, 8'h20, 8'h10, 1'b1, 8'h00, w);
    chk("add_latency", {15'h0, out_valid}, 16'h1);
    // SUB borrow then SUB to zero, back-to-back
    send(3'b001, 8'h10, 8'h20, 8'hF0, 1'b1, 8'h00, w);
    chk("sub_latency", {15'h0, out_valid}, 16'h1);
    send(3'b001, 8'h20, 8'h20, 8'h00, 1'b0, 8'h00, w);
    chk("sub_no_bubble", w[15:0], 16'd0);
    chk("sub2_latency", {15'h0, out_valid}, 16'h1);
    in_valid = 1'b0;
    tick();

    // MUL 0xFF*0xFF = 0xFE01
    send(3'b010, 8'hFF, 8'hFF, 8'h01, 1'b0, 8'hFE, w);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("mul_busy_in_ready_out_valid", {13'h0, busy, in_ready, out_valid}, 16'b100);
      tick();
    end
    chk("mul_done_out_valid", {15'h0, out_valid}, 16'h1);
    chk("mul_done_busy",      {15'h0, busy},      16'h0);

    // Shifts and logic ops, streamed
    send(3'b011, 8'h81, 8'h03, 8'h08, 1'b0, 8'h00, w);
    send(3'b100, 8'h81, 8'h01, 8'h40, 1'b1, 8'h00, w);
    send(3'b011, 8'h81, 8'h00, 8'h81, 1'b0, 8'h00, w);
    send(3'b100, 8'h81, 8'h07, 8'h01, 1'b0, 8'h00, w);
    send(3'b101, 8'hF0, 8'h3C, 8'h30, 1'b0, 8'h00, w);
    send(3'b110, 8'h0F, 8'hF0, 8'hFF, 1'b0, 8'h00, w);
    in_valid = 1'b0;
    tick();

    // Backpressure: result held, pending op refused until release
    out_ready = 1'b0;
    send(3'b111, 8'hAA, 8'h55, 8'hFF, 1'b0, 8'h00, w);
    opcode   = 3'b000;
    A        = 8'h03;
    B        = 8'h04;
    in_valid = 1'b1;
    push(8'h07, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      chk("hold_out_valid", {15'h0, out_valid}, 16'h1);
      chk("hold_Y",         {8'h00, Y},         16'h00FF);
      chk("hold_in_ready",  {15'h0, in_ready},  16'h0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {15'h0, in_ready}, 16'h1);
    tick();
    in_valid = 1'b0;
    chk("release_new_valid", {15'h0, out_valid}, 16'h1);
    chk("release_new_Y",     {8'h00, Y},         16'h0007);
    tick();

    // Reset four cycles after a MUL accept
    send(3'b010, 8'h12, 8'h34, 8'hA8, 1'b0, 8'h03, w);
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("mulrst_out_valid", {15'h0, out_valid}, 16'h0);
    chk("mulrst_busy",      {15'h0, busy},      16'h0);
    chk("mulrst_Y",         {8'h00, Y},         16'h0);
    chk("mulrst_in_ready",  {15'h0, in_ready},  16'h1);
    send(3'b000, 8'h01, 8'h01, 8'h02, 1'b0, 8'h00, w);
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("no_stale_mul", {15'h0, out_valid}, 16'h0);
    chk("scoreboard_empty", sb.size(), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
